// File: rtl/usb2_pkg.sv
// usb2_pkg: shared constants for the USB 2.0 endpoint router.
//   PID_*   : token and handshake PID values
//   SLOT_*  : endpoint buffer slot indices (SLOT_NONE = unmapped endpoint)
//   state_e : router FSM states
//   slot_of / slot_onehot : endpoint number to slot lookup, slot to one-hot mask
package usb2_pkg;

  localparam logic [3:0] PID_OUT   = 4'hE;
  localparam logic [3:0] PID_IN    = 4'h6;
  localparam logic [3:0] PID_SETUP = 4'h2;
  localparam logic [3:0] PID_ACK   = 4'hD;
  localparam logic [3:0] PID_NAK   = 4'h5;
  localparam logic [3:0] PID_STALL = 4'h1;

  localparam logic [1:0] SLOT_EP0  = 2'd0;
  localparam logic [1:0] SLOT_IN   = 2'd1;
  localparam logic [1:0] SLOT_OUT  = 2'd2;
  localparam logic [1:0] SLOT_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_RXDATA,
    ST_CMT_WAIT,
    ST_TXDATA,
    ST_ARM_WAIT
  } state_e;

  function automatic logic [1:0] slot_of(input logic [3:0] endp,
                                         input logic [3:0] in_num,
                                         input logic [3:0] out_num);
    if (endp == 4'd0)         return SLOT_EP0;
    else if (endp == in_num)  return SLOT_IN;
    else if (endp == out_num) return SLOT_OUT;
    return SLOT_NONE;
  endfunction

  function automatic logic [2:0] slot_onehot(input logic [1:0] slot);
    case (slot)
      SLOT_EP0: return 3'b001;
      SLOT_IN:  return 3'b010;
      SLOT_OUT: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/usb2_ep_hold_ack.sv
// usb2_ep_hold_ack: raises a level on start and holds it until the endpoint
// acknowledges, or until the timeout expires. The level is held for at least
// four cycles so endpoints behind 2-flop synchronisers always see it.
//   clk_i     : clock
//   reset_i   : synchronous active-high reset
//   start_i   : one-cycle request to raise the level (ignored while held)
//   ack_i     : acknowledge from the selected endpoint
//   level_o   : held request level
//   done_o    : combinational, high in the last cycle of the level (ack or timeout)
//   timeout_o : combinational, high with done_o when the hold ended on timeout
module usb2_ep_hold_ack #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic ack_i,
  output logic level_o,
  output logic done_o,
  output logic timeout_o
);

  localparam logic [5:0] TMO      = 6'(TIMEOUT);
  localparam logic [5:0] MIN_HOLD = 6'd3;

  logic       level_q, level_d;
  logic [5:0] timer_q, timer_d;

  always_comb begin
    level_d   = level_q;
    timer_d   = timer_q;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (level_q) begin
      if (timer_q != '1) timer_d = timer_q + 6'd1;
      // An early ack is honoured once the minimum hold has elapsed.
      if (ack_i && (timer_q >= MIN_HOLD)) begin
        done_o  = 1'b1;
        level_d = 1'b0;
      end else if (timer_q >= TMO) begin
        done_o    = 1'b1;
        timeout_o = 1'b1;
        level_d   = 1'b0;
      end
    end else if (start_i) begin
      level_d = 1'b1;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q <= 1'b0;
      timer_q <= '0;
    end else begin
      level_q <= level_d;
      timer_q <= timer_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/usb2_ep_router.sv
// usb2_ep_router: routes the protocol layer's single buffer interface to one
// of three endpoint slots (0 = EP0 control, 1 = bulk IN, 2 = bulk OUT), owns
// the bulk data toggles and chooses the handshake PID.
//   tok_*            : decoded token strobe, PID and endpoint number
//   prot_in_*        : protocol-layer receive buffer side (write, commit)
//   prot_out_*       : protocol-layer transmit buffer side (read, arm)
//   prot_data_toggle : data toggle for the current transaction
//   hs_valid/hs_pid  : handshake decision strobe and PID
//   ep_*             : per-slot endpoint buffer signals (3 slots)
//   err_timeout      : sticky commit/arm timeout flag
module usb2_ep_router
  import usb2_pkg::*;
#(
  parameter logic [3:0]  EP_IN_NUM   = 4'd1,
  parameter logic [3:0]  EP_OUT_NUM  = 4'd2,
  parameter int unsigned ACK_TIMEOUT = 63
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic        tok_valid,
  input  logic [3:0]  tok_pid,
  input  logic [3:0]  tok_endp,
  input  logic [8:0]  prot_in_addr,
  input  logic [7:0]  prot_in_data,
  input  logic        prot_in_wren,
  input  logic        prot_in_commit,
  input  logic [9:0]  prot_in_commit_len,
  output logic        prot_in_commit_ack,
  input  logic [8:0]  prot_out_addr,
  output logic [7:0]  prot_out_q,
  output logic [9:0]  prot_out_len,
  output logic        prot_out_hasdata,
  input  logic        prot_out_arm,
  output logic        prot_out_arm_ack,
  output logic [1:0]  prot_data_toggle,
  output logic        hs_valid,
  output logic [3:0]  hs_pid,
  output logic [2:0]  ep_in_wren,
  output logic [2:0]  ep_in_commit,
  input  logic [2:0]  ep_in_commit_ack,
  input  logic [2:0]  ep_in_ready,
  input  logic [23:0] ep_out_q,
  input  logic [29:0] ep_out_len,
  input  logic [2:0]  ep_out_hasdata,
  output logic [2:0]  ep_out_arm,
  input  logic [2:0]  ep_out_arm_ack,
  input  logic [2:0]  ep_stall,
  input  logic [1:0]  ep0_data_toggle,
  output logic        err_timeout
);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [3:0] pid_q;
  logic       hs_valid_q;
  logic [3:0] hs_pid_q;
  logic       cack_q, aack_q;
  logic       err_q;
  logic       tog1_q, tog2_q;
  logic [1:0] ptog_q;
  logic       commit_prev_q, arm_prev_q;

  // Address, data and length buses reach the buffers directly; only the
  // enables and handshakes are gated here.
  logic unused_bus;
  assign unused_bus = ^{prot_in_addr, prot_in_data, prot_in_commit_len, prot_out_addr};

  logic [1:0] tok_slot;
  logic       tok_is_in, tok_is_rx, tok_accept;
  logic [2:0] sel_oh;
  logic       commit_rise, arm_rise, commit_start, arm_start;
  logic       stall_sel, ready_sel, hasdata_sel;
  logic [1:0] slot_tog;
  logic       cmt_level, cmt_done, cmt_tmo;
  logic       arm_level, arm_done, arm_tmo;

  assign tok_slot   = slot_of(tok_endp, EP_IN_NUM, EP_OUT_NUM);
  assign tok_is_in  = (tok_pid == PID_IN);
  assign tok_is_rx  = (tok_pid == PID_OUT) || (tok_pid == PID_SETUP);
  // Unmapped endpoints and direction mismatches are dropped: no handshake.
  assign tok_accept = tok_valid &&
                      ((tok_is_in && (tok_slot == SLOT_EP0 || tok_slot == SLOT_IN)) ||
                       (tok_is_rx && (tok_slot == SLOT_EP0 || tok_slot == SLOT_OUT)));

  assign sel_oh       = slot_onehot(sel_q);
  assign commit_rise  = prot_in_commit & ~commit_prev_q;
  assign arm_rise     = prot_out_arm & ~arm_prev_q;
  assign commit_start = (state_q == ST_RXDATA) && !tok_valid && commit_rise;
  assign arm_start    = (state_q == ST_TXDATA) && arm_rise;

  // SETUP to EP0 must always get through so the host can clear a halt.
  assign stall_sel   = |(ep_stall & sel_oh) && !((pid_q == PID_SETUP) && (sel_q == SLOT_EP0));
  assign ready_sel   = |(ep_in_ready & sel_oh);
  assign hasdata_sel = |(ep_out_hasdata & sel_oh);

  always_comb begin
    case (sel_q)
      SLOT_EP0: slot_tog = ep0_data_toggle;
      SLOT_IN:  slot_tog = {1'b0, tog1_q};
      default:  slot_tog = {1'b0, tog2_q};
    endcase
  end

  always_comb begin
    case (sel_q)
      SLOT_EP0: begin
        prot_out_q   = ep_out_q[7:0];
        prot_out_len = ep_out_len[9:0];
      end
      SLOT_IN: begin
        prot_out_q   = ep_out_q[15:8];
        prot_out_len = ep_out_len[19:10];
      end
      default: begin
        prot_out_q   = ep_out_q[23:16];
        prot_out_len = ep_out_len[29:20];
      end
    endcase
  end
  assign prot_out_hasdata = hasdata_sel;

  usb2_ep_hold_ack #(.TIMEOUT(ACK_TIMEOUT)) u_commit_hold (
    .clk_i     (phy_clk),
    .reset_i   (reset),
    .start_i   (commit_start),
    .ack_i     (|(ep_in_commit_ack & sel_oh)),
    .level_o   (cmt_level),
    .done_o    (cmt_done),
    .timeout_o (cmt_tmo)
  );

  usb2_ep_hold_ack #(.TIMEOUT(ACK_TIMEOUT)) u_arm_hold (
    .clk_i     (phy_clk),
    .reset_i   (reset),
    .start_i   (arm_start),
    .ack_i     (|(ep_out_arm_ack & sel_oh)),
    .level_o   (arm_level),
    .done_o    (arm_done),
    .timeout_o (arm_tmo)
  );

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sel_q         <= SLOT_EP0;
      pid_q         <= '0;
      hs_valid_q    <= 1'b0;
      hs_pid_q      <= PID_NAK;
      cack_q        <= 1'b0;
      aack_q        <= 1'b0;
      err_q         <= 1'b0;
      tog1_q        <= 1'b0;
      tog2_q        <= 1'b0;
      ptog_q        <= '0;
      commit_prev_q <= 1'b0;
      arm_prev_q    <= 1'b0;
    end else begin
      hs_valid_q    <= 1'b0;
      cack_q        <= 1'b0;
      aack_q        <= 1'b0;
      commit_prev_q <= prot_in_commit;
      arm_prev_q    <= prot_out_arm;
      unique case (state_q)
        ST_IDLE: begin
          if (tok_accept) begin
            sel_q   <= tok_slot;
            pid_q   <= tok_pid;
            state_q <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          state_q <= ST_IDLE;
          if (stall_sel) begin
            hs_valid_q <= 1'b1;
            hs_pid_q   <= PID_STALL;
          end else if ((pid_q == PID_IN) ? !hasdata_sel : !ready_sel) begin
            hs_valid_q <= 1'b1;
            hs_pid_q   <= PID_NAK;
          end else begin
            // Toggle is published for OUT too, so the receiver can check DATA0/1.
            ptog_q  <= slot_tog;
            state_q <= (pid_q == PID_IN) ? ST_TXDATA : ST_RXDATA;
          end
        end
        ST_RXDATA: begin
          if (tok_valid)        state_q <= ST_IDLE;
          else if (commit_rise) state_q <= ST_CMT_WAIT;
        end
        ST_CMT_WAIT: begin
          if (cmt_done) begin
            state_q    <= ST_IDLE;
            cack_q     <= 1'b1;
            hs_valid_q <= 1'b1;
            if (cmt_tmo) begin
              err_q    <= 1'b1;
              hs_pid_q <= PID_NAK;
            end else begin
              hs_pid_q <= PID_ACK;
              if (sel_q == SLOT_OUT) tog2_q <= ~tog2_q;
            end
          end
        end
        ST_TXDATA: begin
          if (arm_rise) begin
            state_q <= ST_ARM_WAIT;
          end else if (tok_valid) begin
            // Host never ACKed the data: take the new token as if idle.
            if (tok_accept) begin
              sel_q   <= tok_slot;
              pid_q   <= tok_pid;
              state_q <= ST_DECIDE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ARM_WAIT: begin
          if (arm_done) begin
            state_q <= ST_IDLE;
            aack_q  <= 1'b1;
            if (arm_tmo)                err_q  <= 1'b1;
            else if (sel_q == SLOT_IN)  tog1_q <= ~tog1_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ep_in_wren         = ((state_q == ST_RXDATA) && prot_in_wren) ? sel_oh : '0;
  assign ep_in_commit       = cmt_level ? sel_oh : '0;
  assign ep_out_arm         = arm_level ? sel_oh : '0;
  assign prot_in_commit_ack = cack_q;
  assign prot_out_arm_ack   = aack_q;
  assign prot_data_toggle   = ptog_q;
  assign hs_valid           = hs_valid_q;
  assign hs_pid             = hs_pid_q;
  assign err_timeout        = err_q;

endmodule

// File: doc/usb2_ep_router.md
Name: usb2_ep_router

Overview:
- Sits between the USB 2.0 protocol layer and three endpoint buffers: EP0 control, one bulk IN endpoint, one bulk OUT endpoint.
- Decodes each token, selects the target endpoint, and routes the protocol layer's single buffer interface (write, commit, read, arm) to that endpoint.
- Owns the bulk data toggles and picks the handshake PID: ACK, NAK, STALL, or no response.

Parameters:
- EP_IN_NUM, 1, endpoint number of the bulk IN endpoint (slot 1).
- EP_OUT_NUM, 2, endpoint number of the bulk OUT endpoint (slot 2).
- ACK_TIMEOUT, 63, maximum cycles to wait for commit_ack or arm_ack before aborting.

Ports:
- phy_clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tok_valid  in  1  single-cycle strobe: token received and address matched.
- tok_pid  in  4  token PID (OUT=E, IN=6, SETUP=2).
- tok_endp  in  4  token endpoint number.
- prot_in_addr  in  9  write address, fanned out to all slots.
- prot_in_data  in  8  write data, fanned out to all slots.
- prot_in_wren  in  1  write enable, gated to the selected slot.
- prot_in_commit  in  1  level; packet complete.
- prot_in_commit_len  in  10  committed length, fanned out.
- prot_in_commit_ack  out  1  commit accepted, or aborted on timeout.
- prot_out_addr  in  9  read address, fanned out.
- prot_out_q  out  8  read data from the selected slot.
- prot_out_len  out  10  length from the selected slot.
- prot_out_hasdata  out  1  hasdata from the selected slot.
- prot_out_arm  in  1  level; host ACKed the IN data.
- prot_out_arm_ack  out  1  arm accepted, or aborted on timeout.
- prot_data_toggle  out  2  toggle for the current transaction.
- hs_valid  out  1  one-cycle strobe: handshake decision ready.
- hs_pid  out  4  ACK=D, NAK=5, STALL=1.
- ep_in_wren  out  3  per-slot write enable.
- ep_in_commit  out  3  per-slot commit level.
- ep_in_commit_ack  in  3  per-slot commit acknowledge.
- ep_in_ready  in  3  per-slot ready to accept data.
- ep_out_q  in  24  per-slot read data; slot n occupies bits [8n+7:8n].
- ep_out_len  in  30  per-slot length; slot n occupies bits [10n+9:10n].
- ep_out_hasdata  in  3  per-slot data pending.
- ep_out_arm  out  3  per-slot arm level.
- ep_out_arm_ack  in  3  per-slot arm acknowledge.
- ep_stall  in  3  per-slot halt.
- ep0_data_toggle  in  2  toggle driven by EP0.
- err_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values:
  - state = IDLE; sel = 0.
  - All ep_* outputs, hs_valid, prot_in_commit_ack, prot_out_arm_ack and err_timeout = 0.
  - hs_pid = NAK.
  - Bulk toggles tog1 = tog2 = 0; prot_data_toggle = 0.
  - Reset mid-transaction drops every strobe and level the next cycle; no toggle update occurs.
- Slot map: tok_endp 0 → slot 0; EP_IN_NUM → slot 1; EP_OUT_NUM → slot 2; any other number → unmapped.
- Muxing:
  - Read muxes (prot_out_q, prot_out_len, prot_out_hasdata) select from `sel` combinationally. Read latency equals the slot's buffer latency.
  - prot_in_ready is not a port; ready is evaluated internally only.
- States:
  - IDLE: on tok_valid, latch sel and pid, then go to DECIDE. Unmapped endpoint, or a direction mismatch (IN to slot 2, OUT/SETUP to slot 1), stays in IDLE with no hs_valid (host timeout).
  - DECIDE (1 cycle):
    - STALL if ep_stall[sel], except SETUP to slot 0, which always proceeds.
    - For OUT/SETUP: NAK if ep_in_ready[sel]=0, else go to RXDATA.
    - For IN: NAK if ep_out_hasdata[sel]=0, else drive prot_data_toggle and go to TXDATA.
    - STALL and NAK pulse hs_valid and return to IDLE.
  - RXDATA: ep_in_wren[sel] = prot_in_wren. On a prot_in_commit rising edge, assert ep_in_commit[sel], clear the timer, go to CMT_WAIT. A new tok_valid here aborts silently (host restarted) and returns to IDLE.
  - CMT_WAIT:
    - Hold ep_in_commit[sel] until ep_in_commit_ack[sel].
    - Then pulse prot_in_commit_ack for 1 cycle, pulse hs_valid with ACK, flip tog2 if sel=2, return to IDLE.
    - If the timer reaches ACK_TIMEOUT: set err_timeout, still pulse prot_in_commit_ack, hs_pid = NAK, no toggle change.
  - TXDATA: wait for a prot_out_arm rising edge, then assert ep_out_arm[sel] and go to ARM_WAIT. A new tok_valid with no arm means the host did not ACK: return to IDLE, no toggle change, and reprocess that token.
  - ARM_WAIT: hold ep_out_arm[sel] until ep_out_arm_ack[sel]. Then pulse prot_out_arm_ack for 1 cycle, flip tog1 if sel=1, return to IDLE. Timeout behaves as in CMT_WAIT, without a handshake.
- prot_data_toggle:
  - slot 0: ep0_data_toggle.
  - slot 1: {1'b0, tog1}.
  - slot 2: {1'b0, tog2}.
- Timer: 6-bit, saturating.
- Commit and arm levels stay high at least 4 cycles, because endpoints use 2-flop edge synchronisers. Deassert only after the ack.
- Latency: tok_valid to hs_valid for NAK/STALL is exactly 2 cycles.

Decomposition:
- Package usb2_pkg: PID constants, slot indices, state encodings.
- One sub-module, usb2_ep_hold_ack: level-hold-until-ack with timeout. Instantiated twice, once for commit and once for arm.

Test Plan:
- EP0 SETUP, ep_in_ready[0]=1, 8 writes, commit; ep0 acks after 5 cycles → ep_in_wren seen only on bit 0, one prot_in_commit_ack pulse, hs_pid=D, toggles unchanged.
- IN token to endpoint 1 with hasdata=1, tog1=0 → prot_data_toggle=0; arm, then ack → tog1=1. Second IN → toggle 1.
- OUT token to endpoint 2 with ep_in_ready[2]=0 → hs_valid exactly 2 cycles after tok_valid, hs_pid=5, no ep_in_wren.
- ep_stall[1]=1 with an IN token → hs_pid=1. SETUP to EP0 with ep_stall[0]=1 → proceeds to RXDATA.
- Commit_ack never returns → after 63 cycles err_timeout=1, prot_in_commit_ack pulses, tog2 unchanged.
- Token to endpoint 5, and reset asserted during CMT_WAIT → no hs_valid; all ep_* outputs are 0 the next cycle.
